// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - opcodes, FSM states and constants for the sequential MIPS ALU
package mips_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_RSVD  = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } md_state_e;

  // Replicated across the quotient on divide-by-zero.
  localparam logic DIV0_FILL = 1'b1;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// rtl/alu_muldiv_core.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module alu_muldiv_core
  import mips_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  md_state_e state_q, state_d;

  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     msum, shifted, trial;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIN;
      ST_FIN:  state_d = start_i ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o  = (state_q == ST_RUN);
  assign valid_o = busy_o && (cnt_q == CNT_LAST);

  // Both algorithms share acc_hi/acc_lo: product halves for multiply, remainder/quotient for divide.
  always_comb begin
    a_neg   = is_signed_i & a_i[WIDTH-1];
    b_neg   = is_signed_i & b_i[WIDTH-1];
    mag_a   = a_neg ? -a_i : a_i;
    mag_b   = b_neg ? -b_i : b_i;
    msum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (is_div_q) begin
      step_hi = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      {step_hi, step_lo} = {msum, acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = {step_hi, step_lo};
    hi_o = step_hi;
    lo_o = step_lo;
    if (!is_div_q) begin
      if (neg_res_q) prod = -prod;
      {hi_o, lo_o} = prod;
    end else if (div0_q) begin
      hi_o = a_raw_q;
      lo_o = {WIDTH{DIV0_FILL}};
    end else begin
      lo_o = neg_res_q ? -step_lo : step_lo;
      hi_o = neg_rem_q ? -step_hi : step_hi;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    if (start_i && !busy_o) begin
      cnt_d     = '0;
      acc_hi_d  = '0;
      acc_lo_d  = mag_a;
      opnd_d    = mag_b;
      a_raw_d   = a_i;
      is_div_d  = is_div_i;
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      div0_d    = (b_i == '0);
    end else if (busy_o) begin
      cnt_d    = cnt_q + 1'b1;
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - execute-stage ALU: single-cycle ops plus iterative mul/div into HI/LO
module alu_seq_muldiv
  import mips_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             lt,
  output logic             gt,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  logic             accept, op_md;
  logic             md_busy, md_valid;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, dif, alu_res;
  logic             alu_ovf, lt_c, gt_c, ltu_c;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             lt_p_q, lt_p_d;
  logic             gt_p_q, gt_p_d;

  assign op_md  = is_muldiv(aluop);
  assign accept = start && !md_busy;

  alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (accept && op_md),
    .is_div_i    (aluop[1]),
    .is_signed_i (~aluop[0]),
    .a_i         (data1),
    .b_i         (data2),
    .busy_o      (md_busy),
    .valid_o     (md_valid),
    .hi_o        (md_hi),
    .lo_o        (md_lo)
  );

  always_comb begin
    shamt   = data1[SHW-1:0];
    sum     = data1 + data2;
    dif     = data1 - data2;
    lt_c    = $signed(data1) < $signed(data2);
    gt_c    = $signed(data1) > $signed(data2);
    ltu_c   = data1 < data2;
    alu_ovf = 1'b0;
    alu_res = '0;
    case (aluop)
      OP_AND:  alu_res = data1 & data2;
      OP_OR:   alu_res = data1 | data2;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (data1[MSB] == data2[MSB]) && (sum[MSB] != data1[MSB]);
      end
      OP_NOR:  alu_res = ~(data1 | data2);
      OP_XOR:  alu_res = data1 ^ data2;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ltu_c};
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (data1[MSB] != data2[MSB]) && (dif[MSB] != data1[MSB]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_c};
      OP_SLL:  alu_res = data2 << shamt;
      OP_SRL:  alu_res = data2 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(data2) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Compare flags for mul/div are taken at start but only published with the result.
  always_comb begin
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    lt_p_d   = lt_p_q;
    gt_p_d   = gt_p_q;
    if (accept && op_md) begin
      lt_p_d = lt_c;
      gt_p_d = gt_c;
    end else if (accept) begin
      result_d = alu_res;
      zero_d   = (alu_res == '0);
      lt_d     = lt_c;
      gt_d     = gt_c;
      ovf_d    = alu_ovf;
      done_d   = 1'b1;
    end
    if (md_valid) begin
      hi_d     = md_hi;
      lo_d     = md_lo;
      result_d = md_lo;
      zero_d   = (md_lo == '0);
      lt_d     = lt_p_q;
      gt_d     = gt_p_q;
      ovf_d    = 1'b0;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      lt_p_q   <= 1'b0;
      gt_p_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      lt_p_q   <= lt_p_d;
      gt_p_q   <= gt_p_d;
    end
  end

  assign busy   = md_busy;
  assign done   = done_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign zero   = zero_q;
  assign lt     = lt_q;
  assign gt     = gt_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb/tb_alu_seq_muldiv.sv - randomized bench for alu_seq_muldiv at WIDTH 32, 16 and 8
module tb_alu_seq_muldiv;
  import mips_alu_pkg::*;

  typedef struct packed {
    logic [31:0] res, hi, lo;
    logic zero, lt, gt, ovf, md;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst, st32, st_s;
  logic [3:0]  op32, op_s;
  logic [31:0] a32, b32;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;

  logic        busy32, done32, zero32, lt32, gt32, ovf32;
  logic [31:0] res32, hi32, lo32;
  logic        busy16, done16, zero16, lt16, gt16, ovf16;
  logic [15:0] res16, hi16, lo16;
  logic        busy8, done8, zero8, lt8, gt8, ovf8;
  logic [7:0]  res8, hi8, lo8;

  logic [51:0] cap16;
  logic [27:0] cap8;
  int          lat16, lat8;

  alu_seq_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st32), .aluop(op32), .data1(a32), .data2(b32),
    .busy(busy32), .done(done32), .result(res32), .hi(hi32), .lo(lo32),
    .zero(zero32), .lt(lt32), .gt(gt32), .ovf(ovf32));

  alu_seq_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st_s), .aluop(op_s), .data1(a16), .data2(b16),
    .busy(busy16), .done(done16), .result(res16), .hi(hi16), .lo(lo16),
    .zero(zero16), .lt(lt16), .gt(gt16), .ovf(ovf16));

  alu_seq_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st_s), .aluop(op_s), .data1(a8), .data2(b8),
    .busy(busy8), .done(done8), .result(res8), .hi(hi8), .lo(lo8),
    .zero(zero8), .lt(lt8), .gt(gt8), .ovf(ovf8));

  // Reference: operands as mathematical integers, results reduced modulo 2**w.
  function automatic exp_t model(input int w, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] hi_old,
                                 input logic [31:0] lo_old);
    exp_t e;
    longint mask, half, ua, ub, sa, sb, v;
    int sh;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua >= half) ? ua - (mask + 1) : ua;
    sb = (ub >= half) ? ub - (mask + 1) : ub;
    sh = int'(ua % longint'(w));
    e.hi = hi_old; e.lo = lo_old; e.ovf = 1'b0; e.md = op[3] & op[2]; v = 0;
    case (op)
      4'd0:  v = ua & ub;
      4'd1:  v = ua | ub;
      4'd2:  begin v = sa + sb; e.ovf = (v >= half) || (v < -half); end
      4'd3:  v = ~(ua | ub);
      4'd4:  v = ua ^ ub;
      4'd5:  v = (ua < ub) ? 1 : 0;
      4'd6:  begin v = sa - sb; e.ovf = (v >= half) || (v < -half); end
      4'd7:  v = (sa < sb) ? 1 : 0;
      4'd8:  v = ub << sh;
      4'd9:  v = ub >> sh;
      4'd10: v = sb >>> sh;
      4'd11: v = 0;
      4'd12: begin v = sa * sb; e.lo = 32'(v & mask); e.hi = 32'((v >> w) & mask); end
      4'd13: begin v = ua * ub; e.lo = 32'(v & mask); e.hi = 32'((v >> w) & mask); end
      4'd14: begin
        if (ub == 0) begin e.lo = 32'(mask); e.hi = 32'(ua); end
        else begin e.lo = 32'((sa / sb) & mask); e.hi = 32'((sa % sb) & mask); end
      end
      default: begin
        if (ub == 0) begin e.lo = 32'(mask); e.hi = 32'(ua); end
        else begin e.lo = 32'((ua / ub) & mask); e.hi = 32'((ua % ub) & mask); end
      end
    endcase
    e.res  = e.md ? e.lo : 32'(v & mask);
    e.zero = (e.res == 32'd0);
    e.lt   = (sa < sb);
    e.gt   = (sa > sb);
    return e;
  endfunction

  function automatic logic [31:0] rnd_opnd(input int w);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'(longint'(1) << (w - 1));
      3: return 32'((longint'(1) << (w - 1)) - 1);
      4: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n);
    @(negedge clk); op32 = op; a32 = a; b32 = b; st32 = 1'b1;
    @(posedge clk); @(negedge clk); st32 = 1'b0;
    lat = 1; busy_n = 0;
    while (!done32 && lat < 100) begin
      if (busy32) busy_n++;
      @(posedge clk); @(negedge clk); lat++;
    end
  endtask

  task automatic issue_small(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    op_s = op; a16 = a[15:0]; b16 = b[15:0]; a8 = a[7:0]; b8 = b[7:0]; st_s = 1'b1;
    @(posedge clk); @(negedge clk); st_s = 1'b0;
    n = 1; lat16 = 0; lat8 = 0;
    while ((lat16 == 0 || lat8 == 0) && n < 60) begin
      if (done16 && lat16 == 0) begin
        lat16 = n; cap16 = {res16, hi16, lo16, zero16, lt16, gt16, ovf16};
      end
      if (done8 && lat8 == 0) begin
        lat8 = n; cap8 = {res8, hi8, lo8, zero8, lt8, gt8, ovf8};
      end
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy32, done32, res32, hi32, lo32, zero32, lt32, gt32, ovf32} !== '0) begin
      errors++;
      $display("FAIL reset32 got busy=%b done=%b res=%h hi=%h lo=%h flags=%b%b%b%b exp all zero",
               busy32, done32, res32, hi32, lo32, zero32, lt32, gt32, ovf32);
    end
    checks++;
    if ({busy16, done16, res16, hi16, lo16, busy8, done8, res8, hi8, lo8} !== '0) begin
      errors++;
      $display("FAIL reset_small got r16=%h h16=%h l16=%h r8=%h h8=%h l8=%h exp all zero",
               res16, hi16, lo16, res8, hi8, lo8);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_ovf();
    int lat, bn;
    issue32(OP_ADD, 32'h7FFF_FFFF, 32'd1, lat, bn);
    checks++;
    if ({lat, bn, res32, ovf32, lt32, gt32, zero32} !== {32'd1, 32'd0, 32'h8000_0000, 4'b1010}) begin
      errors++;
      $display("FAIL add_ovf got lat=%0d busy=%0d res=%h ovf=%b lt=%b gt=%b z=%b exp lat=1 busy=0 res=80000000 ovf=1 lt=0 gt=1 z=0",
               lat, bn, res32, ovf32, lt32, gt32, zero32);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); op32 = OP_SUB; a32 = 32'd5; b32 = 32'd5; st32 = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({done32, res32, zero32, lt32, gt32, ovf32} !== {1'b1, 32'd0, 4'b1000}) begin
      errors++;
      $display("FAIL b2b_sub got done=%b res=%h z=%b lt=%b gt=%b ovf=%b exp done=1 res=0 z=1 lt=0 gt=0 ovf=0",
               done32, res32, zero32, lt32, gt32, ovf32);
    end
    op32 = OP_SLT; a32 = 32'hFFFF_FFFF; b32 = 32'd1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({done32, res32, zero32, lt32, gt32} !== {1'b1, 32'd1, 3'b010}) begin
      errors++;
      $display("FAIL b2b_slt got done=%b res=%h z=%b lt=%b gt=%b exp done=1 res=1 z=0 lt=1 gt=0",
               done32, res32, zero32, lt32, gt32);
    end
    st32 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({done32, res32, lt32} !== {1'b0, 32'd1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_hold got done=%b res=%h lt=%b exp done=0 res=1 lt=1", done32, res32, lt32);
    end
  endtask

  task automatic test_shift();
    int lat, bn;
    logic [31:0] v;
    issue32(OP_SRA, 32'd4, 32'h8000_0000, lat, bn);
    checks++;
    if (res32 !== 32'hF800_0000) begin
      errors++; $display("FAIL sra got %h exp f8000000", res32);
    end
    v = $urandom;
    issue32(OP_SLL, 32'd33, v, lat, bn);
    checks++;
    if (res32 !== (v << 1)) begin
      errors++; $display("FAIL sll_shamt got %h exp %h", res32, v << 1);
    end
    issue32(OP_SRL, 32'd31, 32'h8000_0000, lat, bn);
    checks++;
    if (res32 !== 32'd1) begin
      errors++; $display("FAIL srl got %h exp 00000001", res32);
    end
  endtask

  task automatic test_mult();
    int lat, bn;
    issue32(OP_MULT, -32'sd3, 32'd7, lat, bn);
    checks++;
    if ({lat, bn, busy32} !== {32'd33, 32'd32, 1'b0}) begin
      errors++; $display("FAIL mult_latency got lat=%0d busy=%0d exp lat=33 busy=32", lat, bn);
    end
    checks++;
    if ({hi32, lo32, res32} !== {64'hFFFF_FFFF_FFFF_FFEB, 32'hFFFF_FFEB}) begin
      errors++; $display("FAIL mult got hi=%h lo=%h res=%h exp ffffffff ffffffeb", hi32, lo32, res32);
    end
    issue32(OP_MULTU, 32'hFFFF_FFFF, 32'd2, lat, bn);
    checks++;
    if ({hi32, lo32} !== 64'h0000_0001_FFFF_FFFE) begin
      errors++; $display("FAIL multu got hi=%h lo=%h exp 00000001 fffffffe", hi32, lo32);
    end
  endtask

  task automatic test_div();
    int lat, bn;
    issue32(OP_DIV, -32'sd7, 32'd2, lat, bn);
    checks++;
    if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL div got hi=%h lo=%h exp ffffffff fffffffd", hi32, lo32);
    end
    issue32(OP_DIVU, 32'd100, 32'd0, lat, bn);
    checks++;
    if ({lat, hi32, lo32} !== {32'd33, 32'd100, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL divu_zero got lat=%0d hi=%h lo=%h exp lat=33 hi=64 lo=ffffffff", lat, hi32, lo32);
    end
    issue32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
    checks++;
    if ({hi32, lo32} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL div_minneg got hi=%h lo=%h exp 00000000 80000000", hi32, lo32);
    end
  endtask

  task automatic test_ignore_and_abort();
    int lat, quiet;
    logic [31:0] a, b;
    exp_t e;
    a = $urandom | 32'h0001_0001; b = $urandom | 32'h0001_0001;
    e = model(32, OP_MULT, a, b, 32'd0, 32'd0);
    @(negedge clk); op32 = OP_MULT; a32 = a; b32 = b; st32 = 1'b1;
    @(posedge clk); @(negedge clk);
    lat = 1;
    while (!done32 && lat < 100) begin
      st32 = (lat >= 2 && lat <= 10);
      op32 = OP_ADD; a32 = $urandom; b32 = $urandom;
      @(posedge clk); @(negedge clk); lat++;
    end
    st32 = 1'b0;
    checks++;
    if ({lat, hi32, lo32} !== {32'd33, e.hi, e.lo}) begin
      errors++; $display("FAIL ignore_start got lat=%0d hi=%h lo=%h exp lat=33 hi=%h lo=%h", lat, hi32, lo32, e.hi, e.lo);
    end
    @(negedge clk); op32 = OP_MULT; a32 = a; b32 = b; st32 = 1'b1;
    @(posedge clk); @(negedge clk); st32 = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (busy32 !== 1'b1) begin
      errors++; $display("FAIL abort_busy_before got %b exp 1", busy32);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy32, done32, hi32, lo32, res32} !== '0) begin
      errors++; $display("FAIL abort got busy=%b done=%b hi=%h lo=%h res=%h exp all zero", busy32, done32, hi32, lo32, res32);
    end
    quiet = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (done32 || busy32) quiet++; end
    checks++;
    if (quiet !== 0) begin
      errors++; $display("FAIL abort_no_done got %0d active cycles exp 0", quiet);
    end
  endtask

  task automatic test_random32();
    int lat, bn;
    logic [3:0] op;
    logic [31:0] a, b, eh, el;
    exp_t e;
    eh = 32'd0; el = 32'd0;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = rnd_opnd(32); b = rnd_opnd(32);
      e = model(32, op, a, b, eh, el);
      issue32(op, a, b, lat, bn);
      checks++;
      if ({res32, hi32, lo32, zero32, lt32, gt32, ovf32} !== {e.res, e.hi, e.lo, e.zero, e.lt, e.gt, e.ovf}) begin
        errors++;
        $display("FAIL rand32 op=%0d a=%h b=%h got res=%h hi=%h lo=%h f=%b%b%b%b exp res=%h hi=%h lo=%h f=%b%b%b%b",
                 op, a, b, res32, hi32, lo32, zero32, lt32, gt32, ovf32, e.res, e.hi, e.lo, e.zero, e.lt, e.gt, e.ovf);
      end
      checks++;
      if (lat !== (e.md ? 33 : 1)) begin
        errors++; $display("FAIL rand32_latency op=%0d got %0d exp %0d", op, lat, e.md ? 33 : 1);
      end
      eh = e.hi; el = e.lo;
    end
  endtask

  task automatic test_sweep();
    logic [3:0] op;
    logic [31:0] a, b, h16, l16, h8, l8;
    exp_t e16, e8;
    h16 = 0; l16 = 0; h8 = 0; l8 = 0;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = rnd_opnd(i[0] ? 16 : 8); b = rnd_opnd(i[0] ? 16 : 8);
      e16 = model(16, op, a, b, h16, l16);
      e8  = model(8, op, a, b, h8, l8);
      issue_small(op, a, b);
      checks++;
      if (cap16 !== {e16.res[15:0], e16.hi[15:0], e16.lo[15:0], e16.zero, e16.lt, e16.gt, e16.ovf}) begin
        errors++; $display("FAIL sweep16 op=%0d a=%h b=%h got %h exp %h", op, a[15:0], b[15:0], cap16,
                           {e16.res[15:0], e16.hi[15:0], e16.lo[15:0], e16.zero, e16.lt, e16.gt, e16.ovf});
      end
      checks++;
      if (cap8 !== {e8.res[7:0], e8.hi[7:0], e8.lo[7:0], e8.zero, e8.lt, e8.gt, e8.ovf}) begin
        errors++; $display("FAIL sweep8 op=%0d a=%h b=%h got %h exp %h", op, a[7:0], b[7:0], cap8,
                           {e8.res[7:0], e8.hi[7:0], e8.lo[7:0], e8.zero, e8.lt, e8.gt, e8.ovf});
      end
      checks++;
      if ({lat16, lat8} !== {(e16.md ? 32'd17 : 32'd1), (e8.md ? 32'd9 : 32'd1)}) begin
        errors++; $display("FAIL sweep_latency op=%0d got %0d/%0d exp %0d/%0d", op, lat16, lat8,
                           e16.md ? 17 : 1, e8.md ? 9 : 1);
      end
      h16 = e16.hi; l16 = e16.lo; h8 = e8.hi; l8 = e8.lo;
    end
  endtask

  initial begin
    rst = 1'b1; st32 = 1'b0; st_s = 1'b0; op32 = 4'd0; op_s = 4'd0;
    a32 = '0; b32 = '0; a16 = '0; b16 = '0; a8 = '0; b8 = '0;
    cap16 = '0; cap8 = '0; lat16 = 0; lat8 = 0;
    test_reset();
    test_add_ovf();
    test_back_to_back();
    test_shift();
    test_mult();
    test_div();
    test_ignore_and_abort();
    test_random32();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
